// File: rtl/rx_frame_ctrl_pkg.sv
// Shared types and constants for the receive frame controller.
// Frame layout is SYNC, ADDR, DATA, CHK with CHK = ADDR ^ DATA.
package rx_frame_ctrl_pkg;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_e;

    localparam int          NUM_CH        = 4;
    localparam int          BYTE_W        = 8;
    localparam int          CH_W          = 2;
    localparam int          CNT_W         = 8;
    localparam int          TMR_W         = 16;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'h55;

    // A frame is accepted only when the check byte matches and the address names a real channel.
    function automatic logic frame_ok(input logic [BYTE_W-1:0] addr,
                                      input logic [BYTE_W-1:0] data,
                                      input logic [BYTE_W-1:0] chk);
        logic sum_ok;
        logic addr_ok;
        sum_ok  = (chk == (addr ^ data));
        addr_ok = (addr[BYTE_W-1:CH_W] == 6'd0);
        return sum_ok && addr_ok;
    endfunction

endpackage

// File: rtl/byte_timer.sv
// Inter-byte gap counter; expired asserts while enabled once the count
// has reached TIMEOUT-1 without being cleared.
module byte_timer
    import rx_frame_ctrl_pkg::*;
#(
    parameter logic [TMR_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;
    logic             at_limit_s;

    assign at_limit_s = (cnt_q == (TIMEOUT - 16'd1));
    assign expired    = en && at_limit_s;

    // Next count: clear wins, then count up while enabled, holding at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !at_limit_s) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: parses SYNC/ADDR/DATA/CHK frames from a byte
// receiver and writes one of four channel level registers per good frame.
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [TMR_W-1:0]  TIMEOUT   = 16'd50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     byte_valid,
    input  logic [BYTE_W-1:0]        byte_data,
    input  logic                     fmt_err,
    output logic [NUM_CH*BYTE_W-1:0] ch_level,
    output logic                     upd,
    output logic [CH_W-1:0]          upd_ch,
    output logic                     frame_err,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     busy
);

    state_e                          state_q, state_d;
    logic                            arm_q;
    logic                            bv_q;
    logic                            fe_q;
    logic [BYTE_W-1:0]               addr_q, addr_d;
    logic [BYTE_W-1:0]               data_q, data_d;
    logic [NUM_CH-1:0][BYTE_W-1:0]   ch_q, ch_d;
    logic                            upd_q, upd_d;
    logic [CH_W-1:0]                 upd_ch_q, upd_ch_d;
    logic                            ferr_q, ferr_d;
    logic [CNT_W-1:0]                errcnt_q, errcnt_d;
    logic                            busy_q;

    logic                            byte_ev_s;
    logic                            err_ev_s;
    logic                            discard_s;
    logic                            expired_s;
    logic                            tmr_clr_s;
    logic                            tmr_en_s;

    // arm_q masks the first cycle after reset so levels already high are not seen as rises.
    assign byte_ev_s = arm_q && byte_valid && !bv_q;
    assign err_ev_s  = arm_q && fmt_err && !fe_q;

    assign tmr_en_s  = (state_q != S_SYNC);
    assign tmr_clr_s = byte_ev_s || (state_q == S_SYNC);

    byte_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr_s),
        .en      (tmr_en_s),
        .expired (expired_s)
    );

    // Frame parser: an error event beats a byte, and a byte beats the timeout.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ch_d      = ch_q;
        upd_d     = 1'b0;
        upd_ch_d  = upd_ch_q;
        discard_s = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (byte_ev_s && !err_ev_s && (byte_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_ADDR: begin
                if (err_ev_s) begin
                    discard_s = 1'b1;
                end else if (byte_ev_s) begin
                    addr_d  = byte_data;
                    state_d = S_DATA;
                end else if (expired_s) begin
                    discard_s = 1'b1;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (err_ev_s) begin
                    discard_s = 1'b1;
                end else if (byte_ev_s) begin
                    data_d  = byte_data;
                    state_d = S_CHK;
                end else if (expired_s) begin
                    discard_s = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CHK: begin
                if (err_ev_s) begin
                    discard_s = 1'b1;
                end else if (byte_ev_s) begin
                    state_d = S_SYNC;
                    if (frame_ok(addr_q, data_q, byte_data)) begin
                        ch_d[addr_q[CH_W-1:0]] = data_q;
                        upd_d                  = 1'b1;
                        upd_ch_d               = addr_q[CH_W-1:0];
                    end else begin
                        discard_s = 1'b1;
                    end
                end else if (expired_s) begin
                    discard_s = 1'b1;
                end else begin
                    state_d = S_CHK;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (discard_s) begin
            state_d  = S_SYNC;
            ferr_d   = 1'b1;
            errcnt_d = (errcnt_q == 8'hFF) ? errcnt_q : (errcnt_q + 8'd1);
        end else begin
            ferr_d   = 1'b0;
            errcnt_d = errcnt_q;
        end
    end

    // All controller state, including edge-detect history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_SYNC;
            arm_q    <= 1'b0;
            bv_q     <= 1'b0;
            fe_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ch_q     <= '0;
            upd_q    <= 1'b0;
            upd_ch_q <= '0;
            ferr_q   <= 1'b0;
            errcnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            arm_q    <= 1'b1;
            bv_q     <= byte_valid;
            fe_q     <= fmt_err;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            upd_q    <= upd_d;
            upd_ch_q <= upd_ch_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
            busy_q   <= (state_d != S_SYNC);
        end
    end

    assign ch_level  = ch_q;
    assign upd       = upd_q;
    assign upd_ch    = upd_ch_q;
    assign frame_err = ferr_q;
    assign err_cnt   = errcnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever upd or frame_err appears.
module tb_rx_frame_ctrl;

    localparam int TIMEOUT = 50000;

    typedef struct {
        logic        is_err;
        logic [1:0]  ch;
        logic [31:0] lvl;
        logic [7:0]  ec;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        fmt_err;
    logic [31:0] ch_level;
    logic        upd;
    logic [1:0]  upd_ch;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    exp_t        sb_q[$];
    logic [31:0] chm;
    logic [7:0]  errm;
    int          cyc;
    int          total;
    int          bad;

    rx_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .fmt_err    (fmt_err),
        .ch_level   (ch_level),
        .upd        (upd),
        .upd_ch     (upd_ch),
        .frame_err  (frame_err),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_upd(input logic [1:0] ch, input logic [7:0] val, input int ev);
        exp_t e;
        chm[ch*8 +: 8] = val;
        e.is_err = 1'b0;
        e.ch     = ch;
        e.lvl    = chm;
        e.ec     = errm;
        e.cyc    = ev;
        sb_q.push_back(e);
    endtask

    task automatic push_err(input int ev);
        exp_t e;
        if (errm != 8'hFF) errm = errm + 8'd1;
        e.is_err = 1'b1;
        e.ch     = 2'd0;
        e.lvl    = chm;
        e.ec     = errm;
        e.cyc    = ev;
        sb_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fe, output int ev);
        @(posedge clk);
        #1;
        byte_data  = b;
        byte_valid = 1'b1;
        fmt_err    = fe;
        @(posedge clk);
        #1;
        ev         = cyc;
        byte_valid = 1'b0;
        fmt_err    = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, output int ev);
        int t;
        send_byte(b0, 1'b0, t);
        send_byte(b1, 1'b0, t);
        send_byte(b2, 1'b0, t);
        send_byte(b3, 1'b0, ev);
    endtask

    task automatic drain(input string nm, input int max);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({nm, "_pending"}, sb_q.size(), 32'd0);
    endtask

    // Monitor: every upd/frame_err pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst && upd && frame_err) begin
            total++;
            bad++;
            $display("FAIL upd_and_err: both high at cycle %0d", cyc);
        end
        if (rst && (upd || frame_err)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: upd=%0d frame_err=%0d at cycle %0d, none expected",
                         upd, frame_err, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("kind_is_err", {31'd0, frame_err}, {31'd0, e.is_err});
                chk("out_cycle", cyc, e.cyc);
                if (!e.is_err) chk("upd_ch", {30'd0, upd_ch}, {30'd0, e.ch});
                chk("ch_level", ch_level, e.lvl);
                chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.ec});
            end
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb_q.size());
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        int t;
        total      = 0;
        bad        = 0;
        chm        = 32'd0;
        errm       = 8'd0;
        rst        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        fmt_err    = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ch_level", ch_level, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_upd", {31'd0, upd}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Good frame to channel 2.
        send4(8'h55, 8'h02, 8'h7F, 8'h7D, ev);
        push_upd(2'd2, 8'h7F, ev);
        drain("good_ch2", 10);
        chk("good_ch2_level", ch_level, 32'h007F_0000);

        // Bad checksum.
        send4(8'h55, 8'h01, 8'h10, 8'h00, ev);
        push_err(ev);
        drain("bad_chk", 10);
        chk("bad_chk_cnt", {24'd0, err_cnt}, 32'd1);
        chk("bad_chk_busy", {31'd0, busy}, 32'd0);

        // Address out of range with correct checksum.
        send4(8'h55, 8'h05, 8'hAA, 8'hAF, ev);
        push_err(ev);
        drain("bad_addr", 10);
        chk("bad_addr_cnt", {24'd0, err_cnt}, 32'd2);

        // Timeout after the address byte.
        send_byte(8'h55, 1'b0, t);
        send_byte(8'h01, 1'b0, ev);
        @(negedge clk);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        push_err(ev + TIMEOUT);
        drain("timeout", TIMEOUT + 20);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_cnt", {24'd0, err_cnt}, 32'd3);
        send4(8'h55, 8'h00, 8'h11, 8'h11, ev);
        push_upd(2'd0, 8'h11, ev);
        drain("after_timeout", 10);
        chk("after_timeout_level", ch_level, 32'h007F_0011);

        // Sync value used as data; frame right after a previous one.
        send4(8'h55, 8'h03, 8'h55, 8'h56, ev);
        push_upd(2'd3, 8'h55, ev);
        drain("ch3", 10);

        // Error event coinciding with the data byte.
        send_byte(8'h55, 1'b0, t);
        send_byte(8'h03, 1'b0, t);
        send_byte(8'h44, 1'b1, ev);
        push_err(ev);
        drain("fmt_err_data", 10);
        chk("fmt_err_data_cnt", {24'd0, err_cnt}, 32'd4);
        chk("fmt_err_data_busy", {31'd0, busy}, 32'd0);

        // Error event while idle is ignored.
        @(posedge clk);
        #1 fmt_err = 1'b1;
        repeat (3) @(posedge clk);
        #1 fmt_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_fmt_err_cnt", {24'd0, err_cnt}, 32'd4);

        // Saturate the discard counter.
        for (int i = 0; i < 256; i++) begin
            send4(8'h55, 8'h01, 8'h10, 8'h00, ev);
            push_err(ev);
        end
        drain("saturate", 20);
        chk("saturated_cnt", {24'd0, err_cnt}, 32'hFF);

        // Reset mid-frame, with byte_valid held high across the release.
        send_byte(8'h55, 1'b0, t);
        send_byte(8'h03, 1'b0, t);
        send_byte(8'h44, 1'b0, t);
        #2;
        rst        = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        #1;
        chm  = 32'd0;
        errm = 8'd0;
        chk("mid_rst_level", ch_level, 32'd0);
        chk("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_upd_ch", {30'd0, upd_ch}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("held_valid_busy", {31'd0, busy}, 32'd0);
        byte_valid = 1'b0;
        send4(8'h55, 8'h01, 8'h22, 8'h23, ev);
        push_upd(2'd1, 8'h22, ev);
        drain("post_rst", 10);
        chk("post_rst_level", ch_level, 32'h0000_2200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter: SYNC_BYTE, 8'h55, frame start marker.
REQ-002 Parameter: TIMEOUT, 16'd50000, max clk cycles allowed between consecutive bytes of one frame.
REQ-003 Port: clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 Port: byte_valid  input  1  receiver byte-ready flag.
REQ-006 Port: byte_data  input  8  receiver byte, stable while byte_valid high.
REQ-007 Port: fmt_err  input  1  receiver stop-bit error flag, level.
REQ-008 Port: ch_level  output  32  four 8-bit channel levels; channel n in bits [8n+7:8n].
REQ-009 Port: upd  output  1  one-cycle pulse, a channel was written.
REQ-010 Port: upd_ch  output  2  index of channel written, valid with upd.
REQ-011 Port: frame_err  output  1  one-cycle pulse, frame discarded.
REQ-012 Port: err_cnt  output  8  saturating count of discarded frames.
REQ-013 Port: busy  output  1  high in any state other than S_SYNC.

Function
REQ-014 Frame format: SYNC_BYTE, ADDR, DATA, CHK; CHK = ADDR xor DATA.
REQ-015 The block SHALL act on rising edges only: byte event = byte_valid high this cycle and low the previous cycle; error event = same rule on fmt_err.
REQ-016 States: S_SYNC, S_ADDR, S_DATA, S_CHK.
REQ-017 S_SYNC: byte event equal to SYNC_BYTE -> S_ADDR; any other byte is ignored, with no error.
REQ-018 S_ADDR: byte event -> latch ADDR, go to S_DATA; a SYNC_BYTE value here is a normal address byte, with no resync.
REQ-019 S_DATA: byte event -> latch DATA, go to S_CHK.
REQ-020 S_CHK: byte event with CHK match and ADDR[7:2]==0 -> commit; otherwise discard; either case -> S_SYNC.
REQ-021 Commit: on the cycle after the CHK byte event, ch_level[ADDR[1:0]] = DATA, upd=1 for exactly one cycle, upd_ch=ADDR[1:0]; other channels unchanged.
REQ-022 Discard: on the cycle after the triggering event, frame_err=1 for exactly one cycle, and err_cnt increments, holding at 8'hFF.
REQ-023 Discard triggers: checksum mismatch, ADDR>3, an error event in S_ADDR/S_DATA/S_CHK, or a timeout.
REQ-024 Timeout: an inter-byte counter clears on every byte event and on entry to S_ADDR; in S_ADDR/S_DATA/S_CHK, reaching TIMEOUT-1 with no byte event -> discard, S_SYNC.
REQ-025 An error event in S_SYNC SHALL be ignored and SHALL NOT change err_cnt.
REQ-026 If a byte event and an error event occur in the same cycle, the error event wins and the byte is dropped.
REQ-027 If a byte event and the timeout occur in the same cycle, the byte event wins.
REQ-028 upd and frame_err SHALL never both be high in the same cycle.
REQ-029 Byte-event-to-upd latency SHALL be 1 cycle; the block SHALL accept back-to-back frames with no dead cycles.

Reset
REQ-030 While rst=0: state=S_SYNC, ch_level=0, upd=0, upd_ch=0, frame_err=0, err_cnt=0, busy=0, timeout counter=0, latched ADDR/DATA=0, edge-detect history=0.
REQ-031 A reset asserted mid-frame SHALL abandon the frame with no upd and no err_cnt change.
REQ-032 After rst deasserts, a byte_valid or fmt_err already high SHALL NOT count as an event.

Structure
REQ-033 State encodings, SYNC_BYTE default, NUM_CH=4 and the width constants SHALL be defined in the shared project header.
REQ-034 The inter-byte timeout counter SHALL be a sub-module byte_timer (inputs clk, rst, clr, en; output expired).
REQ-035 All registered state SHALL use one sequential block with next-state combinational logic.

Verification
REQ-036 Good frame 55,02,7F,7D -> one cycle after the CHK event: upd=1, upd_ch=2, ch_level[23:16]=7F; err_cnt stays 0.
REQ-037 Bad checksum 55,01,10,00 -> frame_err pulse, err_cnt=1, ch_level unchanged, state S_SYNC.
REQ-038 Bad address 55,05,AA,AF -> frame_err pulse, err_cnt increments, no upd.
REQ-039 55,01 then idle for TIMEOUT cycles -> frame_err pulse at the TIMEOUT-1 count, busy=0; the next good frame 55,00,11,11 -> ch_level[7:0]=11.
REQ-040 fmt_err rises in S_DATA, in the same cycle as a byte_valid rise -> frame_err, no upd; fmt_err rising in S_SYNC -> no error; 256 bad frames -> err_cnt=FF (saturated).
REQ-041 Reset asserted after 55,03,44 -> all outputs 0; byte_valid held high across the release -> no event until it falls and rises again.
